// File: rtl/rgb_line_buffer_3row_pkg.sv
// Shared definitions for the RGB 3-row line buffer: default geometry,
// per-channel packing slots inside a pixel word and the control FSM encoding.
package rgb_conv_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int IMG_W_DEF      = 224;
    localparam int IMG_H_DEF      = 224;

    // Channel slot inside a {b,g,r} word, in units of DATA_WIDTH (r in LSBs)
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } lbuf_state_t;

    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_line_buffer_3row_if.sv
// Pixel-in / column-out bundle of the 3-row line buffer.
// LBUF_COORD_EN adds the col_x/col_y coordinate outputs.
interface rgb_line_buffer_3row_if #(
    parameter int DATA_WIDTH = rgb_conv_pkg::DATA_WIDTH_DEF
`ifdef LBUF_COORD_EN
    ,
    parameter int IMG_W = rgb_conv_pkg::IMG_W_DEF,
    parameter int IMG_H = rgb_conv_pkg::IMG_H_DEF
`endif
) ();

    localparam int PW = 3 * DATA_WIDTH;

    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [PW-1:0] in_pix;

    logic          col_valid;
    logic          col_ready;
    logic [PW-1:0] input_col_r;
    logic [PW-1:0] input_col_g;
    logic [PW-1:0] input_col_b;
    logic          frame_done;

`ifdef LBUF_COORD_EN
    localparam int XW = rgb_conv_pkg::coord_width(IMG_W);
    localparam int YW = rgb_conv_pkg::coord_width(IMG_H);

    logic [XW-1:0] col_x;
    logic [YW-1:0] col_y;

    // Environment side: pixel source and column sink
    modport master (
        output in_valid, in_sof, in_pix, col_ready,
        input  in_ready, col_valid, input_col_r, input_col_g, input_col_b,
        input  frame_done, col_x, col_y
    );

    modport slave (
        input  in_valid, in_sof, in_pix, col_ready,
        output in_ready, col_valid, input_col_r, input_col_g, input_col_b,
        output frame_done, col_x, col_y
    );
`else
    // Environment side: pixel source and column sink
    modport master (
        output in_valid, in_sof, in_pix, col_ready,
        input  in_ready, col_valid, input_col_r, input_col_g, input_col_b,
        input  frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_pix, col_ready,
        output in_ready, col_valid, input_col_r, input_col_g, input_col_b,
        output frame_done
    );
`endif

endinterface

// File: rtl/rgb_line_buffer_3row_line_ram_1r1w.sv
// One image row of pixel storage: asynchronous read, synchronous write.
// Contents are deliberately not reset; rows 0-1 of every frame overwrite them.
module line_ram_1r1w #(
    parameter int DEPTH = 224,
    parameter int WIDTH = 24,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_raddr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/rgb_line_buffer_3row.sv
// Raster RGB stream to 3-row vertical columns for the 3x3 convolution stage.
// Optional LBUF_COORD_EN adds col_x/col_y registered alongside each column.
module rgb_line_buffer_3row
    import rgb_conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rgb_line_buffer_3row_if.slave bus
);

    localparam int PW = 3 * DATA_WIDTH;
    localparam int XW = coord_width(IMG_W);
    localparam int YW = coord_width(IMG_H);

    localparam int R_LSB = CH_R * DATA_WIDTH;
    localparam int G_LSB = CH_G * DATA_WIDTH;
    localparam int B_LSB = CH_B * DATA_WIDTH;

    localparam logic [XW-1:0] X_LAST      = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_FIRST_COL = YW'(2);

    lbuf_state_t   r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    logic          r_col_valid;
    logic          r_col_last;
    logic          r_frame_done;
    logic [PW-1:0] r_col_r;
    logic [PW-1:0] r_col_g;
    logic [PW-1:0] r_col_b;

    logic          w_accept;
    logic          w_restart;
    logic          w_row_end;
    logic          w_frame_end;
    logic          w_emit;
    logic          w_col_taken;
    logic [XW-1:0] w_x;
    logic [XW-1:0] w_x_next;
    logic [YW-1:0] w_y;
    logic [YW-1:0] w_y_next;
    logic [PW-1:0] w_lb0_rd;
    logic [PW-1:0] w_lb1_rd;
    logic [PW-1:0] w_col_r;
    logic [PW-1:0] w_col_g;
    logic [PW-1:0] w_col_b;

    assign bus.in_ready = !r_col_valid || bus.col_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_col_taken  = r_col_valid && bus.col_ready;

    // Start-of-frame or an idle FSM pins the accepted pixel to (0,0)
    assign w_restart   = bus.in_sof || (r_state == ST_IDLE);
    assign w_x         = w_restart ? '0 : r_x;
    assign w_y         = w_restart ? '0 : r_y;
    assign w_row_end   = (w_x == X_LAST);
    assign w_frame_end = w_row_end && (w_y == Y_LAST);
    assign w_x_next    = w_row_end ? '0 : w_x + XW'(1);
    assign w_y_next    = w_frame_end ? '0 : (w_row_end ? w_y + YW'(1) : w_y);
    assign w_emit      = w_accept && (w_y >= Y_FIRST_COL);

    // lb0 holds row y-1, lb1 row y-2; both shift down on every accept
    line_ram_1r1w #(
        .DEPTH (IMG_W),
        .WIDTH (PW),
        .AW    (XW)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_x),
        .i_wdata (bus.in_pix),
        .i_raddr (w_x),
        .o_rdata (w_lb0_rd)
    );

    line_ram_1r1w #(
        .DEPTH (IMG_W),
        .WIDTH (PW),
        .AW    (XW)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_x),
        .i_wdata (w_lb0_rd),
        .i_raddr (w_x),
        .o_rdata (w_lb1_rd)
    );

    assign w_col_r = {bus.in_pix[R_LSB +: DATA_WIDTH], w_lb0_rd[R_LSB +: DATA_WIDTH],
                      w_lb1_rd[R_LSB +: DATA_WIDTH]};
    assign w_col_g = {bus.in_pix[G_LSB +: DATA_WIDTH], w_lb0_rd[G_LSB +: DATA_WIDTH],
                      w_lb1_rd[G_LSB +: DATA_WIDTH]};
    assign w_col_b = {bus.in_pix[B_LSB +: DATA_WIDTH], w_lb0_rd[B_LSB +: DATA_WIDTH],
                      w_lb1_rd[B_LSB +: DATA_WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else if (w_accept) begin
            r_x <= w_x_next;
            r_y <= w_y_next;
            if (w_frame_end) begin
                r_state <= ST_IDLE;
            end else if (w_y_next >= Y_FIRST_COL) begin
                r_state <= ST_STREAM;
            end else begin
                r_state <= ST_FILL;
            end
        end
    end

    // Single output stage: a new column may load in the cycle the old one leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_valid  <= 1'b0;
            r_col_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_col_r      <= '0;
            r_col_g      <= '0;
            r_col_b      <= '0;
        end else begin
            r_frame_done <= w_col_taken && r_col_last;
            if (w_emit) begin
                r_col_valid <= 1'b1;
                r_col_last  <= w_frame_end;
                r_col_r     <= w_col_r;
                r_col_g     <= w_col_g;
                r_col_b     <= w_col_b;
            end else if (w_col_taken) begin
                r_col_valid <= 1'b0;
            end
        end
    end

    assign bus.col_valid   = r_col_valid;
    assign bus.input_col_r = r_col_r;
    assign bus.input_col_g = r_col_g;
    assign bus.input_col_b = r_col_b;
    assign bus.frame_done  = r_frame_done;

`ifdef LBUF_COORD_EN
    logic [XW-1:0] r_col_x;
    logic [YW-1:0] r_col_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_x <= '0;
            r_col_y <= '0;
        end else if (w_emit) begin
            r_col_x <= w_x;
            r_col_y <= w_y;
        end
    end

    assign bus.col_x = r_col_x;
    assign bus.col_y = r_col_y;
`endif

endmodule

// File: doc/rgb_line_buffer_3row.md
Name: rgb_line_buffer_3row

Overview:
Upstream feeder for the RGB 3x3 systolic convolution stage.
- Accepts a raster-order RGB pixel stream, one pixel per handshake.
- Buffers two previous image rows per channel.
- Emits one 3-row vertical column per accepted pixel, in exactly the input_col_r/g/b packing the convolution stage consumes.
- Uses valid/ready on both sides, so camera/DMA stalls and downstream back-pressure are absorbed.

Parameters:
DATA_WIDTH, 8, bits per colour sample
IMG_W, 224, pixels per row; line-buffer depth
IMG_H, 224, rows per frame

Ports:
clk  in  1  single clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  pixel present
in_ready  out  1  block can accept pixel this cycle
in_sof  in  1  start of frame; sampled only on accepted pixel
in_pix  in  3*DATA_WIDTH  {b,g,r}, r in LSBs
col_valid  out  1  output column valid
col_ready  in  1  downstream accepts column
input_col_r  out  3*DATA_WIDTH  {row y, row y-1, row y-2}; row y-2 in LSBs
input_col_g  out  3*DATA_WIDTH  same packing, green
input_col_b  out  3*DATA_WIDTH  same packing, blue
frame_done  out  1  one-cycle pulse when last column of frame is handshaked

Behaviour:
- Reset (rst_n low, async):
  - Outputs: col_valid=0, input_col_*=0, frame_done=0.
  - State IDLE; x=0, y=0.
  - in_ready=1 after reset (it is combinational).
  - Line-buffer contents are not reset.
- Accept and flow control:
  - Accept = in_valid && in_ready.
  - in_ready = !col_valid || col_ready (single output register, no bubble).
- Line buffers:
  - lb0 holds row y-1; lb1 holds row y-2; each is IMG_W x 3*DATA_WIDTH.
  - On accept at column x: read lb0[x] and lb1[x], then write lb1[x]<=lb0[x] and lb0[x]<=in_pix in the same cycle (read-before-write).
- Output:
  - When y>=2, the accept loads the output register with {in_pix, lb0[x], lb1[x]} split per channel, and sets col_valid=1 on the next edge.
  - Latency from accept to output is 1 cycle.
  - When y<2, the accept only fills the line buffers and produces no column.
- Output handshake:
  - Column consumed when col_valid && col_ready.
  - col_valid drops after consumption unless a new column loads in the same cycle.
  - Output data holds stable while col_valid && !col_ready.
- Counters:
  - x increments per accept and wraps at IMG_W-1 -> 0 with y+1.
  - At (IMG_W-1, IMG_H-1) the accept wraps both counters to 0 and the state returns to IDLE.
- FSM:
  - IDLE -> FILL on first accept.
  - FILL -> STREAM when y becomes 2.
  - STREAM -> IDLE after the accept of the last pixel.
  - Columns per frame = (IMG_H-2)*IMG_W.
- frame_done:
  - Asserted one cycle after the handshake of the last frame column.
  - Independent of the next frame's pixels, which may already be accepted.
- in_sof:
  - An accept with in_sof=1 forces that pixel to (0,0) and the state to FILL, from any state.
  - Stale line-buffer data is harmless because rows 0-1 emit nothing.
  - A pending column already in the output register is still delivered.
- in_sof=0 on the first pixel after reset: treated as (0,0) anyway.
- Reset mid-frame: all output state is cleared immediately; a partially filled frame is discarded.

Optional Feature:
LBUF_COORD_EN
- Defined: adds outputs col_x ($clog2(IMG_W) bits) and col_y ($clog2(IMG_H) bits). They hold the x and y of row y of the current column, are registered with the column data, and reset to 0.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (rgb_conv_pkg):
  - DATA_WIDTH default, IMG_W/IMG_H defaults.
  - Pixel packing positions (R/G/B LSB offsets).
  - FSM state encoding: IDLE=0, FILL=1, STREAM=2.
- One sub-module: line_ram_1r1w (IMG_W deep, 3*DATA_WIDTH wide, async read, sync write), instantiated twice (lb0, lb1).

Test Plan:
- Stream with IMG_W=4, IMG_H=4, col_ready=1, r=16y+x, g=r+64, b=r+128:
  - First column is input_col_r={8'd32,8'd16,8'd0}, input_col_g={96,80,64}, input_col_b={160,144,128}.
  - Exactly 8 columns per frame, then frame_done pulses once.
- Back-pressure: hold col_ready=0 for 5 cycles mid-row -> in_ready=0, output data stable, no pixel lost; all columns are in order after release.
- Gapped input: in_valid random 50% -> column sequence identical to the gap-free run.
- in_sof asserted at pixel (2,1) -> that pixel becomes (0,0); no column until the third new row; pending column still delivered.
- Async reset asserted while col_valid=1 -> col_valid=0 and frame_done=0 immediately; the next frame streams correctly from a fresh in_sof.
- With LBUF_COORD_EN: the column from pixel (3,2) reports col_x=3, col_y=2.
